instr_field_decoder: RTL and testbench
======================================

# instr_field_decoder

Registered, parametrised instruction field decoder. It accepts 32-bit RV32I/RV64I instruction words over a valid/ready handshake and classifies the format. It generates the sign-extended immediate at XLEN width and buffers the decoded results in a small FIFO. The block sits between instruction fetch and the multi-cycle controller, so the controller can apply back-pressure without re-fetching.

## Interface
- XLEN, 32: immediate output width; legal values are 32 and 64.
- DEPTH, 2: decoded-entry buffer depth; must be a power of two and ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block can accept a word this cycle.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry this cycle.
- out_rs1, out_rs2, out_rd  out  5 each  raw fields: instr[19:15], instr[24:20], instr[11:7].
- out_opcode  out  7  raw instr[6:0].
- out_funct3  out  3  raw instr[14:12].
- out_funct7  out  7  raw instr[31:25].
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  out  1  opcode not recognised.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Decode is combinational on in_instr. The decoded bundle is written into the FIFO on push, where push = in_valid & in_ready.
- Format decode by opcode:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else, including instr[1:0] ≠ 11 → fmt 7, out_illegal = 1, imm = 0.
- Immediate construction; every result is sign-extended from instr[31] to XLEN:
  - R: imm = 0.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Raw fields are always passed through, whatever the format.
- Pop = out_valid & out_ready; it advances the read pointer.
- Pointers wrap modulo DEPTH.
- Outputs present the head entry when count > 0. All data outputs are 0 when count = 0.
- in_ready = (count < DEPTH) & ~flush.
  - Full: in_ready = 0, so a word cannot arrive in the same cycle as a full-state pop. No pass-through.
  - Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Flush: count, read and write pointers → 0 on the next edge. A pop in the same cycle has no effect beyond the flush, and no push occurs.

## Timing
- Latency: a word accepted at edge N appears on outputs with out_valid = 1 after edge N; no combinational input→output path.
- out_valid = (count ≠ 0), from registered state only.
- in_ready depends only on count and flush, never on out_ready.
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0.
  - out_valid = 0, all data outputs = 0.
  - in_ready = 1 once rst_n is high and flush is low.
  - Reset mid-stream discards all entries immediately.
- Throughput: one word per cycle sustained when out_ready is held high.

## Test plan
- Reset/I-type: assert rst_n low mid-stream → out_valid=0, count=0 immediately. Release, push 0xFFF10093 (addi x1,x2,-1), out_ready=1 → next cycle out_valid=1, rs1=2, rd=1, fmt=1, imm=0xFFFFFFFF.
- Formats:
  - 0x00512423 (sw x5,8(x2)) → fmt=2, rs1=2, rs2=5, imm=8.
  - 0xFE000EE3 (beq x0,x0,-4) → fmt=3, imm=0xFFFFFFFC.
  - 0x123450B7 (lui x1,0x12345) → fmt=4, imm=0x12345000.
  - 0x00000000 → fmt=7, illegal=1, imm=0.
- Back-pressure, DEPTH=2: out_ready=0, in_valid=1 for three words → in_ready falls after two pushes and count=2. Then out_ready=1 → entries emerge in order and the third word is accepted after the first pop.
- Simultaneous: count=1, push and pop in the same cycle → count stays 1 and the new word becomes head the next cycle.
- Flush: count=2, assert flush with in_valid=1 → next cycle count=0, out_valid=0, and the offered word is not stored.
- XLEN=64: push 0xFFF10093 → imm=0xFFFFFFFFFFFFFFFF. Push 0x800000B7 → imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/instr_field_decoder.sv
// Registered RV32I/RV64I instruction field decoder.
// Decodes the instruction format, the raw register/opcode fields and the
// sign-extended immediate, then queues the decoded bundle in a small FIFO so
// the downstream controller can stall without causing a re-fetch.
module instr_field_decoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [XLEN-1:0]            out_imm,
  output logic [2:0]                 out_fmt,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem [DEPTH];
  logic [31:0]     imm32;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  // Accept only while space remains; a flush cycle never stores the offered word.
  assign in_ready = (cnt < CW'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Combinational decode of the incoming word into a FIFO entry.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.opcode = in_instr[6:0];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    case (in_instr[6:0])
      7'b0110011: dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    // Every 32-bit immediate already carries instr[31] as its MSB.
    dec.imm = XLEN'($signed(imm32));
  end

  // Entry storage; contents are masked at the output while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Pointer and occupancy bookkeeping; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Head entry, forced to zero while the buffer is empty.
  always_comb begin
    head = '0;
    if (cnt != '0) head = mem[rd_ptr];
  end

  assign out_valid   = (cnt != '0);
  assign count       = cnt;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_opcode  = head.opcode;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_instr_field_decoder.sv
// Bench for instr_field_decoder: XLEN=32 and XLEN=64 instances share one
// stimulus stream and are compared against a queue-of-words reference model.
module tb_instr_field_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        r32, v32, il32, r64, v64, il64;
  logic [4:0]  rs1_32, rs2_32, rd_32, rs1_64, rs2_64, rd_64;
  logic [6:0]  op32, f7_32, op64, f7_64;
  logic [2:0]  f3_32, fmt32, f3_64, fmt64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [1:0]  c32, c64;

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  instr_field_decoder #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .out_valid(v32), .out_ready(out_ready),
    .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd_32), .out_opcode(op32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(il32), .count(c32));

  instr_field_decoder #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .out_valid(v64), .out_ready(out_ready),
    .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd_64), .out_opcode(op64),
    .out_funct3(f3_64), .out_funct7(f7_64), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(il64), .count(c64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the ISA immediate layouts.
  function automatic void ref_dec(input logic [31:0] i, output logic [2:0] f,
                                  output logic [63:0] imm);
    logic [63:0] s;
    s = {64{i[31]}};
    imm = 64'd0;
    case (i[6:0])
      7'h33: f = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: begin f = 3'd1; imm = {s[63:12], i[31:20]}; end
      7'h23: begin f = 3'd2; imm = {s[63:12], i[31:25], i[11:7]}; end
      7'h63: begin f = 3'd3; imm = {s[63:13], i[31], i[7], i[30:25], i[11:8], 1'b0}; end
      7'h37, 7'h17: begin f = 3'd4; imm = {s[63:32], i[31:12], 12'd0}; end
      7'h6f: begin f = 3'd5; imm = {s[63:21], i[31], i[19:12], i[20], i[30:21], 1'b0}; end
      default: f = 3'd7;
    endcase
  endfunction

  // Compare both instances against the model's current head.
  task automatic mcheck();
    int n;
    logic [31:0] h;
    logic [2:0]  f;
    logic [63:0] im;
    logic [31:0] fld;
    n = q.size();
    h = (n != 0) ? q[0] : 32'd0;
    ref_dec(h, f, im);
    fld = (n != 0) ? {h[19:15], h[24:20], h[11:7], h[6:0], h[14:12], h[31:25]} : 32'd0;
    chk("count32", 64'(c32), 64'(n));
    chk("count64", 64'(c64), 64'(n));
    chk("out_valid", 64'({v32, v64}), (n != 0) ? 64'd3 : 64'd0);
    chk("in_ready", 64'({r32, r64}), (n < 2 && !flush) ? 64'd3 : 64'd0);
    chk("fields32", 64'({rs1_32, rs2_32, rd_32, op32, f3_32, f7_32}), 64'(fld));
    chk("fields64", 64'({rs1_64, rs2_64, rd_64, op64, f3_64, f7_64}), 64'(fld));
    chk("fmt", 64'({fmt32, fmt64}), (n != 0) ? 64'({f, f}) : 64'd0);
    chk("illegal", 64'({il32, il64}), (n != 0 && f == 3'd7) ? 64'd3 : 64'd0);
    chk("imm32", 64'(imm32), (n != 0) ? 64'(im[31:0]) : 64'd0);
    chk("imm64", imm64, (n != 0) ? im : 64'd0);
  endtask

  // One clock: drive at negedge, check model, update model at the edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    bit psh, pp;
    @(negedge clk);
    in_valid = v; in_instr = w; out_ready = rdy; flush = fl;
    #1 mcheck();
    @(posedge clk);
    psh = v && (q.size() < 2) && !fl;
    pp  = (q.size() != 0) && rdy;
    if (!rst_n || fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(w);
    end
    #1;
  endtask

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                          7'h63, 7'h37, 7'h17, 7'h6f, 7'h0b};

  initial begin
    logic [31:0] w;
    #12;
    #1 chk("rst_valid", 64'(v32), 64'd0);
    chk("rst_count", 64'(c32), 64'd0);
    chk("rst_imm", imm64, 64'd0);
    rst_n = 1'b1;

    // I-type then other formats, one per cycle with out_ready high.
    cyc(1, 32'hFFF10093, 1, 0);
    chk("addi_valid", 64'(v32), 64'd1);
    chk("addi_rs1_rd", 64'({rs1_32, rd_32}), 64'({5'd2, 5'd1}));
    chk("addi_fmt", 64'(fmt32), 64'd1);
    chk("addi_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    cyc(1, 32'h00512423, 1, 0);
    chk("sw", 64'({fmt32, rs1_32, rs2_32, imm32}), 64'({3'd2, 5'd2, 5'd5, 32'd8}));
    cyc(1, 32'hFE000EE3, 1, 0);
    chk("beq", 64'({fmt32, imm32}), 64'({3'd3, 32'hFFFFFFFC}));
    cyc(1, 32'h123450B7, 1, 0);
    chk("lui", 64'({fmt32, imm32}), 64'({3'd4, 32'h12345000}));
    cyc(1, 32'h00000000, 1, 0);
    chk("zero_word", 64'({fmt32, il32, imm32}), 64'({3'd7, 1'b1, 32'd0}));
    cyc(1, 32'h800000B7, 1, 0);
    chk("lui64", imm64, 64'hFFFFFFFF80000000);
    cyc(0, 0, 1, 0);
    chk("drained", 64'(c32), 64'd0);

    // Back-pressure: third word waits until after the first pop.
    cyc(1, 32'h00100093, 0, 0);
    cyc(1, 32'h00200113, 0, 0);
    chk("full_cnt", 64'(c32), 64'd2);
    cyc(1, 32'h00300193, 0, 0);
    chk("full_hold", 64'({c32, rd_32}), 64'({2'd2, 5'd1}));
    cyc(1, 32'h00300193, 1, 0);
    chk("pop1", 64'({c32, rd_32}), 64'({2'd1, 5'd2}));
    cyc(1, 32'h00300193, 1, 0);
    chk("third_in", 64'({c32, rd_32}), 64'({2'd1, 5'd3}));
    // Simultaneous push/pop at count 1.
    cyc(1, 32'h00400213, 1, 0);
    chk("simul", 64'({c32, rd_32}), 64'({2'd1, 5'd4}));
    // Flush with a word offered.
    cyc(1, 32'h00500293, 0, 0);
    cyc(1, 32'h00600313, 0, 1);
    chk("flush", 64'({c32, v32}), 64'd0);

    // Mid-stream asynchronous reset.
    cyc(1, 32'h00700393, 0, 0);
    cyc(1, 32'h00800413, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("async_rst", 64'({c32, v32, c64, v64}), 64'd0);
    q.delete();
    cyc(1, 32'h00900493, 1, 0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      w = $urandom;
      if ($urandom_range(9) < 8) w[6:0] = ops[$urandom_range(10)];
      cyc($urandom_range(3) != 0, w, $urandom_range(9) < 6, $urandom_range(15) == 0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
